// File: rtl/write_check_sequencer_pkg.sv
// Shared types and defaults for the write-path check sequencer.
package write_check_sequencer_pkg;

  localparam int DEF_DATA_WIDTH  = 64;
  localparam int DEF_COUNT_WIDTH = 32;
  localparam int DEF_STALL_LIMIT = 1048576;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/write_check_sequencer_if.sv
// FIFO-side and checker-side signals of the sequencer; master is the sequencer.
interface write_check_sequencer_if
  import write_check_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
);

  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_dout;
  logic                  fifo_rd_en;
  logic [DATA_WIDTH-1:0] data_to_check;
  logic                  check_for_errors;
  logic                  enable_pattern;
  logic                  reset_pattern;
  logic                  reset_err_counter;

  modport master (
    input  fifo_empty, fifo_dout,
    output fifo_rd_en, data_to_check, check_for_errors,
           enable_pattern, reset_pattern, reset_err_counter
  );

  modport slave (
    output fifo_empty, fifo_dout,
    input  fifo_rd_en, data_to_check, check_for_errors,
           enable_pattern, reset_pattern, reset_err_counter
  );

endinterface

// File: rtl/write_check_sequencer_stall_timer.sv
// Counts consecutive enabled cycles; raises a sticky flag on the STALL_LIMIT-th one.
module write_check_sequencer_stall_timer
  import write_check_sequencer_pkg::*;
#(
  parameter int STALL_LIMIT = DEF_STALL_LIMIT
) (
  input  logic clk,
  input  logic reset_n,
  input  logic count_en,
  input  logic clear,
  output logic stall_flag
);

  generate
    if (STALL_LIMIT == 0) begin : g_off
      assign stall_flag = 1'b0;
    end else begin : g_on
      localparam int CW = (STALL_LIMIT > 1) ? $clog2(STALL_LIMIT) : 1;
      localparam logic [CW-1:0] LAST = CW'(STALL_LIMIT - 1);

      logic [CW-1:0] cnt_reg;
      logic          flag_reg;

      // Counter saturates at LAST so the flag stays meaningful on long stalls.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          cnt_reg  <= '0;
          flag_reg <= 1'b0;
        end else begin
          if (clear || !count_en)
            cnt_reg <= '0;
          else if (cnt_reg != LAST)
            cnt_reg <= cnt_reg + 1'b1;

          if (clear)
            flag_reg <= 1'b0;
          else if (count_en && cnt_reg == LAST)
            flag_reg <= 1'b1;
        end
      end

      assign stall_flag = flag_reg;
    end
  endgenerate

endmodule

// File: rtl/write_check_sequencer.sv
// Drains pipe-in FIFO words into the error checker with a fixed 2-cycle read-to-check latency.
module write_check_sequencer
  import write_check_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int COUNT_WIDTH = DEF_COUNT_WIDTH,
  parameter int STALL_LIMIT = DEF_STALL_LIMIT
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic [COUNT_WIDTH-1:0] transfer_len,
  output logic [COUNT_WIDTH-1:0] word_count,
  output logic                   busy,
  output logic                   done,
  output logic                   stall_timeout,
  write_check_sequencer_if.master bus
);

  state_t                 state_reg, state_next;
  logic [COUNT_WIDTH-1:0] len_q_reg;
  logic [COUNT_WIDTH-1:0] reads_issued_reg;
  logic [COUNT_WIDTH-1:0] word_count_reg;
  logic [DATA_WIDTH-1:0]  data_reg;
  logic                   rd_valid_reg;
  logic                   check_reg;
  logic                   rd_en;
  logic                   clear_pulse;
  logic                   reads_pending;
  logic                   start_accept;

  assign reads_pending = reads_issued_reg < len_q_reg;
  assign start_accept  = start && !abort &&
                         (state_reg == ST_IDLE || state_reg == ST_DONE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      state_reg <= ST_IDLE;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next  = state_reg;
    rd_en       = 1'b0;
    clear_pulse = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (state_reg)
      ST_IDLE:  if (start) state_next = ST_CLEAR;
      ST_CLEAR: begin
        clear_pulse = 1'b1;
        busy        = 1'b1;
        state_next  = (len_q_reg == '0) ? ST_DONE : ST_RUN;
      end
      ST_RUN: begin
        busy  = 1'b1;
        rd_en = !bus.fifo_empty && reads_pending;
        if (reads_issued_reg == len_q_reg) state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        busy = 1'b1;
        if (word_count_reg == len_q_reg) state_next = ST_DONE;
      end
      ST_DONE: begin
        done = 1'b1;
        if (start) state_next = ST_CLEAR;
      end
      default:  state_next = ST_IDLE;
    endcase
    // Abort overrides everything, including a start in the same cycle.
    if (abort) begin
      state_next = ST_IDLE;
      rd_en      = 1'b0;
    end
  end

  // Counters are zeroed on the accepted start so they already read 0 during CLEAR.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      len_q_reg        <= '0;
      reads_issued_reg <= '0;
      word_count_reg   <= '0;
      data_reg         <= '0;
      rd_valid_reg     <= 1'b0;
      check_reg        <= 1'b0;
    end else begin
      if (start_accept) begin
        len_q_reg        <= transfer_len;
        reads_issued_reg <= '0;
      end else if (rd_en) begin
        reads_issued_reg <= reads_issued_reg + 1'b1;
      end

      if (abort || start_accept) begin
        rd_valid_reg <= 1'b0;
        check_reg    <= 1'b0;
        if (start_accept) word_count_reg <= '0;
      end else begin
        rd_valid_reg <= rd_en;
        check_reg    <= rd_valid_reg;
        if (rd_valid_reg) begin
          data_reg       <= bus.fifo_dout;
          word_count_reg <= word_count_reg + 1'b1;
        end
      end
    end
  end

  write_check_sequencer_stall_timer #(
    .STALL_LIMIT (STALL_LIMIT)
  ) u_stall_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .count_en   (state_reg == ST_RUN && bus.fifo_empty && reads_pending),
    .clear      (start_accept || abort),
    .stall_flag (stall_timeout)
  );

  assign bus.fifo_rd_en        = rd_en;
  assign bus.data_to_check     = data_reg;
  assign bus.check_for_errors  = check_reg;
  assign bus.enable_pattern    = check_reg;
  assign bus.reset_pattern     = clear_pulse;
  assign bus.reset_err_counter = clear_pulse;
  assign word_count            = word_count_reg;

endmodule

// File: tb/tb_write_check_sequencer.sv
// Closed-loop bench: behavioural FIFO and pattern checker around write_check_sequencer.
module tb_write_check_sequencer;

  localparam int DW    = 64;
  localparam int CW    = 32;
  localparam int STALL = 16;

  logic          clk;
  logic          reset_n;
  logic          start;
  logic          abort;
  logic [CW-1:0] transfer_len;
  logic [CW-1:0] word_count;
  logic          busy;
  logic          done;
  logic          stall_timeout;

  write_check_sequencer_if #(.DATA_WIDTH(DW)) bus();

  write_check_sequencer #(
    .DATA_WIDTH  (DW),
    .COUNT_WIDTH (CW),
    .STALL_LIMIT (STALL)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .start         (start),
    .abort         (abort),
    .transfer_len  (transfer_len),
    .word_count    (word_count),
    .busy          (busy),
    .done          (done),
    .stall_timeout (stall_timeout),
    .bus           (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  int          cyc = 0;
  logic [63:0] host_q[$];
  logic [63:0] fifo_q[$];
  int          rd_cyc_q[$];

  int   rd_cnt = 0, stb_cnt = 0, rp_cnt = 0, stb_outside = 0, en_mis = 0;
  int   err_cnt = 0, pat_idx = 0;
  int   first_rd = -1, first_stb = -1, last_stb = -1, done_rise = -1;
  int   empty_run = 0, stall_rise_run = -1, cur_len = 0;
  logic done_prev = 1'b0, stall_prev = 1'b0;

  function automatic logic [63:0] pat(input int i);
    logic [31:0] u;
    u = i;
    return {32'hC0DE_0000 ^ u, u * 32'h9E37_79B9};
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Standard-mode FIFO: dout updates on the edge after rd_en; host writes land one edge later.
  initial begin
    bus.fifo_empty = 1'b1;
    bus.fifo_dout  = '0;
    forever begin
      @(posedge clk);
      cyc++;
      if (bus.fifo_rd_en && fifo_q.size() > 0) bus.fifo_dout <= fifo_q.pop_front();
      while (host_q.size() > 0) fifo_q.push_back(host_q.pop_front());
      bus.fifo_empty <= (fifo_q.size() == 0);
    end
  end

  // Checker model and observation counters, sampled mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (stall_timeout && !stall_prev) stall_rise_run = empty_run;
      stall_prev = stall_timeout;
      if (bus.fifo_rd_en) begin
        rd_cnt++;
        rd_cyc_q.push_back(cyc);
        if (first_rd < 0) first_rd = cyc;
        empty_run = 0;
      end else if (bus.fifo_empty && busy && !bus.reset_pattern && rd_cnt < cur_len) begin
        empty_run++;
      end
      if (bus.reset_pattern) begin
        pat_idx = 0;
        rp_cnt++;
      end
      if (bus.reset_err_counter) err_cnt = 0;
      if (bus.enable_pattern !== bus.check_for_errors) en_mis++;
      if (bus.check_for_errors) begin
        stb_cnt++;
        if (!busy) stb_outside++;
        if (first_stb < 0) first_stb = cyc;
        last_stb = cyc;
        if (bus.data_to_check !== pat(pat_idx)) err_cnt++;
      end
      if (bus.enable_pattern) pat_idx++;
      if (done && !done_prev) done_rise = cyc;
      done_prev = done;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, required finish before time limit");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon(input int len);
    rd_cnt = 0; stb_cnt = 0; rp_cnt = 0;
    first_rd = -1; first_stb = -1; last_stb = -1; done_rise = -1;
    empty_run = 0; stall_rise_run = -1;
    rd_cyc_q.delete();
    cur_len = len;
  endtask

  task automatic push_words(input int first, input int n, input int bad);
    logic [63:0] w;
    for (int k = 0; k < n; k++) begin
      w = pat(first + k);
      if (first + k == bad) w = w ^ (64'd1 << $urandom_range(63, 0));
      host_q.push_back(w);
    end
  endtask

  task automatic start_xfer(input int len);
    clear_mon(len);
    transfer_len = len;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int k;
    k = 0;
    while (!done && k < budget) begin
      tick();
      k++;
    end
    chk({tag, "_done"}, 64'(done), 64'd1);
    tick();
  endtask

  task automatic flush();
    host_q.delete();
    fifo_q.delete();
    tick();
  endtask

  initial begin
    int len, extra, bad, pre, remaining, chunk, k, abort_cyc, exp_stb, exp_rd;
    string tag;
    reset_n = 1'b0; start = 1'b0; abort = 1'b0; transfer_len = '0;

    // Reset state.
    #3;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_wc", 64'(word_count), 64'd0);
    chk("rst_data", bus.data_to_check, 64'd0);
    chk("rst_strobe", 64'(bus.check_for_errors), 64'd0);
    chk("rst_rd_en", 64'(bus.fifo_rd_en), 64'd0);
    chk("rst_stall", 64'(stall_timeout), 64'd0);
    chk("rst_rstpat", 64'(bus.reset_pattern), 64'd0);
    tick(); tick();
    reset_n = 1'b1;
    tick();

    // len=4, preloaded clean words: back-to-back strobes, done one cycle after the last.
    push_words(0, 4, -1);
    tick();
    start_xfer(4);
    wait_done("t1", 100);
    chk("t1_wc", 64'(word_count), 64'd4);
    chk("t1_strobes", 64'(stb_cnt), 64'd4);
    chk("t1_reads", 64'(rd_cnt), 64'd4);
    chk("t1_consecutive", 64'(last_stb - first_stb), 64'd3);
    chk("t1_latency", 64'(first_stb - first_rd), 64'd2);
    chk("t1_done_gap", 64'(done_rise - last_stb), 64'd1);
    chk("t1_errors", 64'(err_cnt), 64'd0);
    chk("t1_clear_cycles", 64'(rp_cnt), 64'd1);
    chk("t1_busy", 64'(busy), 64'd0);

    // len=8 with word 5 corrupted.
    push_words(0, 8, 4);
    tick();
    start_xfer(8);
    wait_done("t2", 100);
    chk("t2_errors", 64'(err_cnt), 64'd1);
    chk("t2_wc", 64'(word_count), 64'd8);

    // len=6 with a FIFO gap after word 2, a stray start mid-run, and surplus words available.
    push_words(0, 2, -1);
    tick();
    start_xfer(6);
    k = 0;
    while (rd_cnt < 2 && k < 50) begin tick(); k++; end
    chk("t3_first_reads", 64'(rd_cnt), 64'd2);
    transfer_len = 20;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    chk("t3_gap_strobes", 64'(stb_cnt), 64'd2);
    chk("t3_gap_busy", 64'(busy), 64'd1);
    chk("t3_start_ignored", 64'(rp_cnt), 64'd1);
    push_words(2, 8, -1);
    wait_done("t3", 100);
    chk("t3_wc", 64'(word_count), 64'd6);
    chk("t3_strobes", 64'(stb_cnt), 64'd6);
    chk("t3_reads", 64'(rd_cnt), 64'd6);
    chk("t3_leftover", 64'(host_q.size() + fifo_q.size()), 64'd4);
    chk("t3_errors", 64'(err_cnt), 64'd0);
    flush();

    // len=0: one CLEAR cycle then DONE, no reads.
    start_xfer(0);
    chk("t4_clear_pulse", 64'(bus.reset_pattern), 64'd1);
    chk("t4_clear_errcnt", 64'(bus.reset_err_counter), 64'd1);
    tick();
    chk("t4_done", 64'(done), 64'd1);
    chk("t4_pulse_gone", 64'(bus.reset_pattern), 64'd0);
    tick();
    chk("t4_reads", 64'(rd_cnt), 64'd0);
    chk("t4_clear_cycles", 64'(rp_cnt), 64'd1);

    // Randomized transfers with staggered host writes and an optional corrupted word.
    for (int r = 0; r < 4; r++) begin
      len   = $urandom_range(12, 1);
      extra = $urandom_range(3, 0);
      bad   = ($urandom_range(1, 0) == 1) ? int'($urandom_range(len + extra - 1, 0)) : -1;
      pre   = $urandom_range(len, 0);
      push_words(0, pre, bad);
      tick();
      start_xfer(len);
      remaining = len + extra - pre;
      while (remaining > 0) begin
        chunk = $urandom_range((remaining < 3) ? remaining : 3, 1);
        repeat ($urandom_range(4, 0)) tick();
        push_words(len + extra - remaining, chunk, bad);
        remaining -= chunk;
      end
      tag = $sformatf("rnd%0d", r);
      wait_done(tag, 300);
      chk({tag, "_wc"}, 64'(word_count), 64'(len));
      chk({tag, "_strobes"}, 64'(stb_cnt), 64'(len));
      chk({tag, "_reads"}, 64'(rd_cnt), 64'(len));
      chk({tag, "_errors"}, 64'(err_cnt), 64'((bad >= 0 && bad < len) ? 1 : 0));
      chk({tag, "_leftover"}, 64'(host_q.size() + fifo_q.size()), 64'(extra));
      chk({tag, "_stall"}, 64'(stall_timeout), 64'd0);
      flush();
    end

    // Stall: only 2 of 4 words ever arrive.
    push_words(0, 2, -1);
    tick();
    start_xfer(4);
    k = 0;
    while (!stall_timeout && k < 100) begin tick(); k++; end
    chk("stall_flag", 64'(stall_timeout), 64'd1);
    tick();
    chk("stall_empty_cycles", 64'(stall_rise_run), 64'(STALL));
    chk("stall_busy", 64'(busy), 64'd1);
    chk("stall_wc", 64'(word_count), 64'd2);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("stall_abort_busy", 64'(busy), 64'd0);
    chk("stall_abort_flag", 64'(stall_timeout), 64'd0);
    chk("stall_abort_done", 64'(done), 64'd0);
    flush();

    // Abort with words in flight: only words read two or more cycles before the abort edge reach the checker.
    push_words(0, 8, -1);
    tick();
    start_xfer(8);
    k = 0;
    while (rd_cnt < 3 && k < 50) begin tick(); k++; end
    abort_cyc = cyc;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick(); tick(); tick();
    exp_stb = 0;
    exp_rd  = 0;
    foreach (rd_cyc_q[i]) begin
      if (rd_cyc_q[i] + 2 <= abort_cyc) exp_stb++;
      if (rd_cyc_q[i] < abort_cyc) exp_rd++;
    end
    chk("abort_strobes", 64'(stb_cnt), 64'(exp_stb));
    chk("abort_wc_hold", 64'(word_count), 64'(exp_stb));
    chk("abort_no_read", 64'(rd_cnt), 64'(exp_rd));
    chk("abort_idle", 64'(busy), 64'd0);
    flush();

    // Asynchronous reset between edges, then a clean len=3 transfer.
    push_words(0, 10, -1);
    tick();
    start_xfer(10);
    repeat (5) tick();
    #1;
    reset_n = 1'b0;
    #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_wc", 64'(word_count), 64'd0);
    chk("arst_data", bus.data_to_check, 64'd0);
    chk("arst_strobe", 64'(bus.check_for_errors), 64'd0);
    chk("arst_rd_en", 64'(bus.fifo_rd_en), 64'd0);
    tick();
    reset_n = 1'b1;
    flush();
    push_words(0, 3, -1);
    tick();
    start_xfer(3);
    wait_done("rerun", 100);
    chk("rerun_wc", 64'(word_count), 64'd3);
    chk("rerun_errors", 64'(err_cnt), 64'd0);

    chk("strobe_outside_busy", 64'(stb_outside), 64'd0);
    chk("enable_matches_check", 64'(en_mis), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
